// File: rtl/apb_cmd_master.sv
// APB3 requester: turns one valid/ready command into one APB read/write transfer.
// Latency: 3 clocks accept-to-response with zero-wait PREADY, +1 per wait state.
// Backpressure: req_ready low from SETUP until the response cycle; response has none.
module apb_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Counter only has to reach TIMEOUT_CYCLES-1; keep it at least one bit wide.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept, complete, abort;

  // State register; asynchronous reset drops PSEL/PENABLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and bus-phase outputs decoded from the state register.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    accept    = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        PSEL      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        // A ready on the timeout edge still counts as a normal completion.
        if (PREADY) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the command; values persist while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (accept) begin
      PWRITE <= req_write;
      PADDR  <= req_addr;
      PWDATA <= req_wdata;
    end
  end

  // Count ACCESS cycles spent waiting for PREADY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (state == SETUP)             cnt <= '0;
    else if (state == ACCESS && !PREADY) cnt <= cnt + 1'b1;
  end

  // One-cycle response strobe; data and error hold until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= complete | abort;
      if (complete) begin
        rsp_err   <= PSLVERR;
        rsp_rdata <= PWRITE ? '0 : PRDATA;
      end else if (abort) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: hand-computed expectations per transfer.
// Latency here is counted in rising edges after the accept edge.
// All DUT outputs are sampled 1 time unit after the rising edge.
module tb_apb_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  int n_chk  = 0;
  int n_pass = 0;

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer. waits = PREADY-low ACCESS cycles before ready; stuck = never ready.
  task automatic xfer(input string tag, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input int waits, input logic stuck, input logic [31:0] rd, input logic err,
                      input logic exp_err, input logic [31:0] exp_rdata);
    int  k;
    bit  done;
    int  exp_lat;
    check({tag, "_rdy"}, req_ready, 1);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = wd;
    PRDATA = rd; PSLVERR = err; PREADY = 0;
    tick();                                        // accept edge
    req_valid = 0; req_write = ~w; req_addr = ~a; req_wdata = ~wd;
    check({tag, "_setup_psel"}, PSEL, 1);
    check({tag, "_setup_pen"}, PENABLE, 0);
    check({tag, "_paddr"}, PADDR, a);
    check({tag, "_pwrite"}, PWRITE, w);
    check({tag, "_pwdata"}, PWDATA, wd);
    tick();                                        // into ACCESS
    check({tag, "_acc_pen"}, PENABLE, 1);
    k = 0; done = 0;
    while (!done && k < 40) begin
      PREADY = !stuck && (k == waits);
      tick();
      k++;
      if (rsp_valid) done = 1;
      else check({tag, "_addr_stable"}, PADDR, a);
    end
    PREADY = 0;
    if (!done) check({tag, "_rsp_timeout"}, 0, 1);
    exp_lat = stuck ? 17 : waits + 2;
    check({tag, "_lat"}, k + 1, exp_lat);
    check({tag, "_err"}, rsp_err, exp_err);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_psel_off"}, {PSEL, PENABLE}, 2'b00);
    check({tag, "_rdy_rsp"}, req_ready, 1);
    tick();
    check({tag, "_strobe_1cyc"}, rsp_valid, 0);
    check({tag, "_rdata_hold"}, rsp_rdata, exp_rdata);
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    PRDATA = 0; PREADY = 0; PSLVERR = 0;
    #12;
    check("rst_psel", PSEL, 0);
    check("rst_pen", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_rdy", req_ready, 1);
    @(posedge clk); #1 rst_n = 1;
    tick();

    // Zero-wait write; PRDATA garbage must not leak into rsp_rdata.
    xfer("wr0", 1, 32'h0000_0000, 32'hA5A5_0001, 0, 0, 32'hDEAD_BEEF, 0, 0, 32'h0);
    // Read with 3 wait states.
    xfer("rd3", 0, 32'h0000_0010, 32'h0, 3, 0, 32'h1234_5678, 0, 0, 32'h1234_5678);
    // Write completing with slave error.
    xfer("wrerr", 1, 32'h0000_0004, 32'h0000_00FF, 1, 0, 32'h5555_5555, 1, 1, 32'h0);
    // Stuck responder: abort after 16 ACCESS cycles.
    xfer("tmo", 0, 32'h0000_0020, 32'h0, 0, 1, 32'h7777_7777, 0, 1, 32'h0);
    // Ready on the 16th ACCESS cycle wins over timeout.
    xfer("tmo_edge", 0, 32'h0000_0024, 32'h0, 15, 0, 32'h0000_CAFE, 0, 0, 32'h0000_CAFE);

    // Back-to-back with req_valid held high.
    req_valid = 1; req_write = 0; req_addr = 32'h100; req_wdata = 0;
    PRDATA = 32'h1111_1111; PSLVERR = 0; PREADY = 1;
    tick();                                        // accept A
    req_write = 1; req_addr = 32'h200; req_wdata = 32'h2222_2222;
    check("b2b_a_paddr", PADDR, 32'h100);
    tick();                                        // ACCESS A
    check("b2b_a_paddr_acc", PADDR, 32'h100);
    tick();                                        // response A, accept B at next edge
    check("b2b_a_rsp", {rsp_valid, rsp_err}, 2'b10);
    check("b2b_a_rdata", rsp_rdata, 32'h1111_1111);
    check("b2b_gap", PSEL, 0);
    check("b2b_rdy", req_ready, 1);
    tick();                                        // accept B
    req_valid = 0;
    check("b2b_b_setup", {PSEL, PENABLE}, 2'b10);
    check("b2b_b_paddr", PADDR, 32'h200);
    check("b2b_b_pwrite", PWRITE, 1);
    tick();
    tick();
    check("b2b_b_rsp", {rsp_valid, rsp_err}, 2'b10);
    check("b2b_b_rdata", rsp_rdata, 32'h0);
    PREADY = 0;
    tick();

    // Reset asserted in the middle of ACCESS.
    req_valid = 1; req_write = 0; req_addr = 32'h40;
    tick();
    req_valid = 0;
    tick();
    tick();
    #2 rst_n = 0;
    #1;
    check("mrst_psel", {PSEL, PENABLE}, 2'b00);
    check("mrst_rsp", rsp_valid, 0);
    check("mrst_paddr", PADDR, 0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_no_rsp", rsp_valid, 0);
    end
    check("mrst_rdy", req_ready, 1);
    xfer("post_rst", 0, 32'h0000_0044, 32'h0, 1, 0, 32'h0BAD_F00D, 0, 0, 32'h0BAD_F00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
